// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes,
// FSM states and the word-alignment mask.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Wide enough for any practical ADDR_W; users slice the low ADDR_W bits.
  localparam logic [63:0] WORD_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_ops.sv
// Combinational lane logic: merges sub-word store data into a memory word
// and extracts/extends sub-word load data, honouring byte order.
module lsu_lane_ops
  import mem_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic [31:0] mem_word,
  input  logic [31:0] wr_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [1:0]  byte_sel_s;
  logic        half_sel_s;
  logic [4:0]  byte_sh_s;
  logic [4:0]  half_sh_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection, store merge and load extension; word size ignores offset.
  always_comb begin
    byte_sel_s = LITTLE_ENDIAN ? offset : ~offset;
    half_sel_s = LITTLE_ENDIAN ? offset[1] : ~offset[1];
    byte_sh_s  = {byte_sel_s, 3'b000};
    half_sh_s  = {half_sel_s, 4'b0000};
    byte_s     = mem_word[byte_sh_s +: 8];
    half_s     = mem_word[half_sh_s +: 16];
    merged     = mem_word;
    extracted  = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        merged[byte_sh_s +: 8] = wr_data[7:0];
        extracted = {{24{sign_ext & byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        merged[half_sh_s +: 16] = wr_data[15:0];
        extracted = {{16{sign_ext & half_s[15]}}, half_s};
      end
      SZ_WORD: begin
        merged    = wr_data;
        extracted = mem_word;
      end
      default: begin
        merged    = mem_word;
        extracted = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of data_memory; sub-word stores use a
// 2-cycle read-modify-write. Define LSU_MISALIGN_TRAP_EN to fault on misalignment.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic              flush,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [31:0]       dmem_write_data,
  input  logic [31:0]       dmem_read_data,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              stall,
  output logic              access_fault
);

  lsu_state_e        state_r;
  logic [31:0]       merge_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       load_data_r;
  logic              load_valid_r;
  logic              fault_r;

  logic              is_idle_s;
  logic              access_s;
  logic              misalign_s;
  logic              fault_s;
  logic              load_s;
  logic              store_s;
  logic              word_store_s;
  logic              sub_store_s;
  logic [ADDR_W-1:0] aligned_addr_s;
  logic [31:0]       merged_s;
  logic [31:0]       extracted_s;

  assign is_idle_s = (state_r == ST_IDLE);
  assign access_s  = is_idle_s & valid_in & ~flush & (mem_read | mem_write);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = ((size == SZ_HALF) & addr[0]) |
                      ((size == SZ_WORD) & (addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign fault_s      = access_s & ((size == SZ_ILLEGAL) | (mem_read & mem_write) | misalign_s);
  assign load_s       = access_s & ~fault_s & mem_read;
  assign store_s      = access_s & ~fault_s & mem_write;
  assign word_store_s = store_s & (size == SZ_WORD);
  assign sub_store_s  = store_s & (size != SZ_WORD);

  assign aligned_addr_s = addr & WORD_ALIGN_MASK[ADDR_W-1:0];

  lsu_lane_ops #(
    .LITTLE_ENDIAN(LITTLE_ENDIAN)
  ) u_lane_ops (
    .mem_word (dmem_read_data),
    .wr_data  (store_data),
    .size     (size),
    .offset   (addr[1:0]),
    .sign_ext (sign_ext),
    .merged   (merged_s),
    .extracted(extracted_s)
  );

  // Gated by reset_n so a write in flight is dropped the instant reset asserts.
  assign dmem_write      = reset_n & (~is_idle_s | word_store_s);
  assign stall           = reset_n & sub_store_s;
  assign dmem_address    = is_idle_s ? aligned_addr_s : addr_r;
  assign dmem_write_data = is_idle_s ? store_data : merge_r;

  assign load_data    = load_data_r;
  assign load_valid   = load_valid_r;
  assign access_fault = fault_r;

  // Control FSM plus registered load result, fault pulse and merge buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      merge_r      <= 32'h0000_0000;
      addr_r       <= '0;
      load_data_r  <= 32'h0000_0000;
      load_valid_r <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      load_valid_r <= load_s;
      fault_r      <= fault_s;
      if (load_s) begin
        load_data_r <= extracted_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (sub_store_s) begin
            merge_r <= merged_s;
            addr_r  <= aligned_addr_s;
            state_r <= ST_RMW_WR;
          end
        end
        ST_RMW_WR: state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit sitting directly upstream of data_memory.
- Accepts EX/MEM memory requests of byte, halfword or word size.
- Drives data_memory's word-wide port. data_memory reads combinationally and writes on the clk posedge.
- Sub-word stores become a 2-cycle read-modify-write with pipeline stall. Returns sign/zero-extended load data registered into the MEM/WB boundary.

Parameters:
- ADDR_W, 32, byte-address width on request and memory side.
- LITTLE_ENDIAN, 1, 1 = byte 0 at bits [7:0]; 0 = byte 0 at bits [31:24].

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- valid_in  in  1  request present this cycle.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend.
- addr  in  ADDR_W  byte address.
- store_data  in  32  store value, right-justified for sub-word.
- flush  in  1  kill the request in the current cycle.
- dmem_write  out  1  to data_memory.write.
- dmem_address  out  ADDR_W  to data_memory.address, always word-aligned (addr & ~3).
- dmem_write_data  out  32  to data_memory.write_data.
- dmem_read_data  in  32  from data_memory.read_data.
- load_data  out  32  registered extended load result.
- load_valid  out  1  one-cycle pulse with load_data.
- stall  out  1  upstream must hold all request inputs.
- access_fault  out  1  one-cycle registered pulse on a faulting request.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - load_data=0, load_valid=0, access_fault=0, merge buffer=0.
  - dmem_write forced 0 immediately; stall=0.
- Request accepted = valid_in & ~flush in IDLE.
- FSM states: IDLE, RMW_WR.
- Word load:
  - Memory address driven combinationally in the same cycle.
  - Next posedge: load_data = dmem_read_data, load_valid=1. Latency 1, no stall.
- Sub-word load:
  - Same timing as a word load.
  - Lane selected by addr[1:0] (half by addr[1]), then extended per sign_ext.
- Word store: dmem_write=1 in the same cycle, write_data=store_data, no stall.
- Sub-word store:
  - IDLE cycle: dmem_write=0, stall=1. Merge store_data into dmem_read_data at the selected lane; latch into the merge buffer. Go to RMW_WR.
  - RMW_WR cycle: dmem_write=1, write_data=merge buffer, stall=0, same aligned address. Return to IDLE.
  - Throughput: one sub-word store per 2 cycles.
- Fault conditions: size=11; mem_read&mem_write; half with addr[0]=1; word with addr[1:0]!=0.
  - No memory write, no load_valid.
  - access_fault=1 at the next posedge for one cycle.
- valid_in with neither mem_read nor mem_write: no-op.
- flush:
  - In IDLE: suppresses the access entirely (no write, no load_valid, no fault).
  - In RMW_WR: ignored; the committed store completes.
- Inputs are ignored in RMW_WR; upstream holds them via stall.
- Back-to-back:
  - A load right after RMW_WR is accepted in the following IDLE cycle.
  - load_valid pulses may be consecutive.
- load_data holds its last value when load_valid=0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned half/word accesses raise access_fault as above.
- Undefined:
  - The misaligned address is silently aligned and the access proceeds: half uses addr[1], word ignores addr[1:0].
  - access_fault fires only for size=11 or mem_read&mem_write.

Decomposition:
- Package mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, WORD_ALIGN_MASK constant.
- One combinational sub-module, lsu_lane_ops:
  - Store-lane merge (old word, data, size, offset → merged word).
  - Load extract/extend (word, size, offset, sign_ext → result).
  - Honours LITTLE_ENDIAN.

Test Plan:
- Word load: memory[12]=3; valid, mem_read, size=10, addr=12 → dmem_address=12, next cycle load_data=3, load_valid=1, stall=0.
- Byte load with sign: memory[20]=0x0000_8000; size=00, addr=21, sign_ext=1 → load_data=0xFFFF_FF80. With sign_ext=0 → 0x0000_0080.
- Sub-word store RMW: memory[20]=0x1122_3344; size=01, addr=22, store_data=0xABCD:
  - Cycle 0: stall=1, dmem_write=0.
  - Cycle 1: dmem_write=1, write_data=0xABCD_3344.
  - A following word load of 20 returns 0xABCD_3344.
- Fault: word load addr=14 → no write, load_valid=0, access_fault pulses 1 cycle. Undefined LSU_MISALIGN_TRAP_EN → loads word at 12 instead.
- Flush: word store addr=20 with flush=1 → dmem_write stays 0, memory unchanged. Flush asserted during RMW_WR → write still occurs.
- Reset mid-RMW: reset_n low in RMW_WR → dmem_write drops immediately, state IDLE, all outputs 0, memory unmodified.
